// File: rtl/glitch_sequencer.sv
// glitch_sequencer: arm/trigger driven scheduler of delayed glitch pulse trains, config shadowed at arm.
// Optional feature macro GLITCH_SWEEP_EN adds a per-sequence delay sweep (offset += cfg_step on DONE).
module glitch_sequencer #(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  logic [WIDTH_W-1:0] cfg_gap,
    input  logic [COUNT_W-1:0] cfg_count,
`ifdef GLITCH_SWEEP_EN
    input  logic [DELAY_W-1:0] cfg_step,
    input  logic               sweep_clr,
    output logic [DELAY_W-1:0] cur_delay,
`endif
    output logic               glitch,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] shots
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [DELAY_W-1:0] CNT_ONE = DELAY_W'(1'b1);
    localparam logic [WIDTH_W-1:0] W_ONE   = WIDTH_W'(1'b1);
    localparam logic [COUNT_W-1:0] N_ONE   = COUNT_W'(1'b1);

    state_t             state_q,  state_d;
    logic               trig_q,   trig_d;
    logic [DELAY_W-1:0] cnt_q,    cnt_d;
    logic [DELAY_W-1:0] d_sh_q,   d_sh_d;
    logic [WIDTH_W-1:0] w_sh_q,   w_sh_d;
    logic [WIDTH_W-1:0] g_sh_q,   g_sh_d;
    logic [COUNT_W-1:0] n_sh_q,   n_sh_d;
    logic [COUNT_W-1:0] pulses_q, pulses_d;
    logic               glitch_q, glitch_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [COUNT_W-1:0] shots_q,  shots_d;

    logic               trig_edge_s;
    logic [DELAY_W-1:0] arm_delay_s;

    // Zero-to-one substitution applied to width/gap shadows at arm time.
    function automatic logic [WIDTH_W-1:0] nz_w(input logic [WIDTH_W-1:0] v);
        if (v == '0) begin
            nz_w = W_ONE;
        end else begin
            nz_w = v;
        end
    endfunction

    // Zero-to-one substitution applied to the pulse-count shadow at arm time.
    function automatic logic [COUNT_W-1:0] nz_n(input logic [COUNT_W-1:0] v);
        if (v == '0) begin
            nz_n = N_ONE;
        end else begin
            nz_n = v;
        end
    endfunction

    assign trig_edge_s = trigger & ~trig_q;

`ifdef GLITCH_SWEEP_EN
    logic [DELAY_W-1:0] offset_q, offset_d;

    assign arm_delay_s = cfg_delay + offset_q;
    assign cur_delay   = arm_delay_s;

    // Sweep offset: cleared on request, otherwise advanced by one step per completed sequence.
    always_comb begin
        offset_d = offset_q;
        if (sweep_clr) begin
            offset_d = '0;
        end else if ((state_q == S_DONE) && !abort) begin
            offset_d = offset_q + cfg_step;
        end else begin
            offset_d = offset_q;
        end
    end

    // Sweep offset register.
    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end
`else
    assign arm_delay_s = cfg_delay;
`endif

    // Next-state, counters, shadows and registered-output decode.
    always_comb begin
        state_d  = state_q;
        trig_d   = trigger;
        cnt_d    = cnt_q;
        d_sh_d   = d_sh_q;
        w_sh_d   = w_sh_q;
        g_sh_d   = g_sh_q;
        n_sh_d   = n_sh_q;
        pulses_d = pulses_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d  = S_ARMED;
                        d_sh_d   = arm_delay_s;
                        w_sh_d   = nz_w(cfg_width);
                        g_sh_d   = nz_w(cfg_gap);
                        n_sh_d   = nz_n(cfg_count);
                        pulses_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (!trig_edge_s) begin
                        state_d = S_ARMED;
                    end else if (d_sh_q == '0) begin
                        state_d  = S_PULSE;
                        cnt_d    = DELAY_W'(w_sh_q);
                        pulses_d = pulses_q + N_ONE;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = d_sh_q;
                    end
                end
                S_DELAY: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d  = S_PULSE;
                        cnt_d    = DELAY_W'(w_sh_q);
                        pulses_d = pulses_q + N_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q != CNT_ONE) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (pulses_q == n_sh_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = DELAY_W'(g_sh_q);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d  = S_PULSE;
                        cnt_d    = DELAY_W'(w_sh_q);
                        pulses_d = pulses_q + N_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are flopped decodes of the current state; abort masks them for the next cycle.
        glitch_d = (state_q == S_PULSE) && !abort;
        busy_d   = (state_q != S_IDLE) && !abort;
        done_d   = (state_q == S_DONE) && !abort;
        if ((state_q != S_IDLE) && !abort) begin
            shots_d = pulses_q;
        end else begin
            shots_d = shots_q;
        end
    end

    // State, counter, shadow and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            trig_q   <= 1'b0;
            cnt_q    <= '0;
            d_sh_q   <= '0;
            w_sh_q   <= '0;
            g_sh_q   <= '0;
            n_sh_q   <= '0;
            pulses_q <= '0;
            glitch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            shots_q  <= '0;
        end else begin
            state_q  <= state_d;
            trig_q   <= trig_d;
            cnt_q    <= cnt_d;
            d_sh_q   <= d_sh_d;
            w_sh_q   <= w_sh_d;
            g_sh_q   <= g_sh_d;
            n_sh_q   <= n_sh_d;
            pulses_q <= pulses_d;
            glitch_q <= glitch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            shots_q  <= shots_d;
        end
    end

    assign glitch = glitch_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign shots  = shots_q;

endmodule
